// File: rtl/modulo_updown_counter.sv
// Modulo-m up/down counter with runtime-loadable modulus, one-shot mode,
// terminal-count flag, wrap pulse, sticky done flag and a cascade wrap counter.
module modulo_updown_counter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned K      = 16,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              dir,
  input  logic              clear,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  mod_k,
  input  logic              oneshot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [WIDTH-1:0] KVal = WIDTH'(K);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    count_q;
  logic [WIDTH-1:0]    m_q;
  logic                wrap_q;
  logic [WRAP_W-1:0]   wraps_q;

  logic [WIDTH-1:0]    m_new;
  logic [WIDTH-1:0]    term;
  logic [WIDTH-1:0]    load_sat;

  // Modulus candidate, terminal value for the current direction and saturated load value.
  always_comb begin
    m_new    = (mod_k == '0) ? KVal : mod_k;
    term     = dir ? (m_q - WIDTH'(1)) : '0;
    load_sat = (load_val >= m_new) ? (m_new - WIDTH'(1)) : load_val;
  end

  // Count, modulus, wrap pulse, wrap counter and RUN/HALT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      count_q <= '0;
      m_q     <= KVal;
      wrap_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        count_q <= '0;
        m_q     <= m_new;
        state_q <= StRun;
        wraps_q <= '0;
      end else if (load) begin
        count_q <= load_sat;
        m_q     <= m_new;
        state_q <= StRun;
      end else if (en && (state_q == StRun)) begin
        if (count_q != term) begin
          count_q <= dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end else begin
          // Terminal step: either halt in place (one-shot) or wrap to the opposite end.
          wrap_q  <= 1'b1;
          wraps_q <= wraps_q + WRAP_W'(1);
          if (oneshot) begin
            state_q <= StHalt;
          end else begin
            count_q <= dir ? '0 : (m_q - WIDTH'(1));
          end
        end
      end
    end
  end

  assign count = count_q;
  assign tc    = (count_q == term);
  assign wrap  = wrap_q;
  assign done  = (state_q == StHalt);
  assign wraps = wraps_q;

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Randomized and directed bench for modulo_updown_counter against an arithmetic model.
module tb_modulo_updown_counter;

  localparam int unsigned W  = 32;
  localparam int unsigned KK = 16;
  localparam int unsigned WW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, dir, clear, load, oneshot;
  logic [W-1:0]  load_val, mod_k;
  logic [W-1:0]  count;
  logic          tc, wrap, done;
  logic [WW-1:0] wraps;

  int total = 0;
  int bad   = 0;

  // Reference model state
  longint unsigned m_m, m_cnt;
  int              m_wraps;
  bit              m_done, m_wrap;

  modulo_updown_counter #(.WIDTH(W), .K(KK), .WRAP_W(WW)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .mod_k    (mod_k),
    .oneshot  (oneshot),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .done     (done),
    .wraps    (wraps)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_m = KK; m_cnt = 0; m_wraps = 0; m_done = 0; m_wrap = 0;
  endtask

  // One clock edge of the behaviour, using plain modular arithmetic.
  task automatic model_edge();
    longint unsigned mn;
    bit              at_end;
    mn     = (mod_k == 0) ? longint'(KK) : longint'(mod_k);
    m_wrap = 0;
    if (clear) begin
      m_cnt = 0; m_m = mn; m_done = 0; m_wraps = 0;
    end else if (load) begin
      m_m    = mn;
      m_cnt  = (longint'(load_val) >= mn) ? mn - 1 : longint'(load_val);
      m_done = 0;
    end else if (en && !m_done) begin
      at_end = dir ? (m_cnt == m_m - 1) : (m_cnt == 0);
      if (at_end) begin
        m_wrap  = 1;
        m_wraps = (m_wraps + 1) % (1 << WW);
        if (oneshot) m_done = 1;
        else m_cnt = (m_cnt + (dir ? 1 : m_m - 1)) % m_m;
      end else begin
        m_cnt = (m_cnt + (dir ? 1 : m_m - 1)) % m_m;
      end
    end
  endtask

  task automatic check_all();
    bit exp_tc;
    exp_tc = dir ? (m_cnt == m_m - 1) : (m_cnt == 0);
    check_val("count", 64'(count), 64'(m_cnt));
    check_val("tc",    64'(tc),    64'(exp_tc));
    check_val("wrap",  64'(wrap),  64'(m_wrap));
    check_val("done",  64'(done),  64'(m_done));
    check_val("wraps", 64'(wraps), 64'(m_wraps));
  endtask

  task automatic step(input logic i_en, input logic i_dir, input logic i_clear,
                      input logic i_load, input logic [W-1:0] i_lv, input logic [W-1:0] i_mk,
                      input logic i_os);
    en = i_en; dir = i_dir; clear = i_clear; load = i_load;
    load_val = i_lv; mod_k = i_mk; oneshot = i_os;
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  initial begin
    reset = 1'b0; en = 0; dir = 1; clear = 0; load = 0; oneshot = 0;
    load_val = '0; mod_k = '0;
    model_reset();
    #22;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Up count through one wrap: 19 steps from 0
    repeat (19) step(1, 1, 0, 0, 0, 0, 0);
    check_val("up19_count", 64'(count), 64'd3);
    check_val("up19_wraps", 64'(wraps), 64'd1);

    // Down from 2 through 0 -> 15
    step(0, 0, 0, 1, 2, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 0);
    check_val("down_count", 64'(count), 64'd14);

    // Load saturation and modulus reselect
    step(0, 1, 0, 1, 100, 10, 0);
    check_val("load_sat", 64'(count), 64'd9);
    step(0, 1, 0, 1, 3, 0, 0);
    check_val("load_3", 64'(count), 64'd3);

    // One-shot with m=5
    step(0, 1, 1, 0, 0, 5, 0);
    repeat (9) step(1, 1, 0, 0, 0, 5, 1);
    check_val("oneshot_count", 64'(count), 64'd4);
    check_val("oneshot_done", 64'(done), 64'd1);
    step(0, 1, 1, 0, 0, 5, 1);
    check_val("clear_done", 64'(done), 64'd0);

    // clear beats load; en=0 holds
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 7, 0, 0);
    check_val("clear_wins", 64'(count), 64'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);

    // Largest modulus: 2^W-1
    step(0, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_val("big_load", 64'(count), 64'hFFFF_FFFE);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Async reset between edges at count=9
    step(0, 1, 1, 0, 0, 0, 0);
    repeat (9) step(1, 1, 0, 0, 0, 0, 0);
    check_val("pre_reset", 64'(count), 64'd9);
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b1;

    // m=1: every enabled step wraps; wraps rolls over
    step(0, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 260; i++) step(1, 1'($urandom_range(0, 1)), 0, 0, 0, 1, 0);
    check_val("m1_wraps", 64'(wraps), 64'd4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] mk, lv;
      case ($urandom_range(0, 3))
        0: mk = '0;
        1: mk = 1;
        2: mk = $urandom_range(2, 20);
        default: mk = $urandom;
      endcase
      lv = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 25)) : W'($urandom);
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           lv, mk, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
